// File: rtl/id_hazard_ctrl_if.sv
// Signal bundle between the ID-stage decoder/pipeline and id_hazard_ctrl.
// master drives decoder/pipeline state; slave is the hazard controller.
interface id_hazard_ctrl_if #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [CTRL_W-1:0] ex_ctrl_dec;
  logic [CTRL_W-1:0] mem_ctrl_dec;
  logic [CTRL_W-1:0] wb_ctrl_dec;
  logic [REG_W-1:0]  id_rn;
  logic [REG_W-1:0]  id_rm;
  logic              id_uses_rn;
  logic              id_uses_rm;
  logic [REG_W-1:0]  idex_rd;
  logic              idex_mem_read;
  logic              branch_taken;
  logic [CTRL_W-1:0] ex_ctrl_out;
  logic [CTRL_W-1:0] mem_ctrl_out;
  logic [CTRL_W-1:0] wb_ctrl_out;
  logic              pc_we;
  logic              if_id_we;
  logic              if_id_flush;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_valid, ex_ctrl_dec, mem_ctrl_dec, wb_ctrl_dec,
           id_rn, id_rm, id_uses_rn, id_uses_rm,
           idex_rd, idex_mem_read, branch_taken,
    input  ex_ctrl_out, mem_ctrl_out, wb_ctrl_out,
           pc_we, if_id_we, if_id_flush, stall_count, flush_count
  );

  modport slave (
    input  id_valid, ex_ctrl_dec, mem_ctrl_dec, wb_ctrl_dec,
           id_rn, id_rm, id_uses_rn, id_uses_rm,
           idex_rd, idex_mem_read, branch_taken,
    output ex_ctrl_out, mem_ctrl_out, wb_ctrl_out,
           pc_we, if_id_we, if_id_flush, stall_count, flush_count
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, branch flushes, bubble insertion.
// Define HAZ_PERF_CNT_EN to build saturating stall/flush bubble counters.
module id_hazard_ctrl #(
  parameter int unsigned CTRL_W       = 4,
  parameter int unsigned REG_W        = 4,
  parameter int unsigned LU_BUBBLES   = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic             clk,
  input logic             reset,
  id_hazard_ctrl_if.slave hz
);

  localparam int unsigned MAXB = (LU_BUBBLES > FLUSH_CYCLES) ? LU_BUBBLES : FLUSH_CYCLES;
  localparam int unsigned CW   = (MAXB < 2) ? 1 : $clog2(MAXB + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t          r_state, w_next_state;
  logic [CW-1:0]   r_cnt, w_next_cnt;
  logic            w_lu;

  assign w_lu = hz.id_valid & hz.idex_mem_read &
                ((hz.id_uses_rn & (hz.id_rn == hz.idex_rd)) |
                 (hz.id_uses_rm & (hz.id_rm == hz.idex_rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Outputs default to a bubble with the front end frozen; each branch opens up what it needs.
  always_comb begin
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;
    hz.ex_ctrl_out  = '0;
    hz.mem_ctrl_out = '0;
    hz.wb_ctrl_out  = '0;
    hz.pc_we        = 1'b0;
    hz.if_id_we     = 1'b0;
    hz.if_id_flush  = 1'b0;
    if (!reset) begin
      if (hz.branch_taken && (r_state != FLUSH || FLUSH_CYCLES > 1)) begin
        hz.pc_we       = 1'b1;
        hz.if_id_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_next_state = FLUSH;
          w_next_cnt   = CW'(FLUSH_CYCLES - 1);
        end else begin
          w_next_state = RUN;
        end
      end else begin
        case (r_state)
          RUN: begin
            if (w_lu) begin
              if (LU_BUBBLES > 1) begin
                w_next_state = LU_STALL;
                w_next_cnt   = CW'(LU_BUBBLES - 1);
              end
            end else begin
              hz.pc_we    = 1'b1;
              hz.if_id_we = 1'b1;
              if (hz.id_valid) begin
                hz.ex_ctrl_out  = hz.ex_ctrl_dec;
                hz.mem_ctrl_out = hz.mem_ctrl_dec;
                hz.wb_ctrl_out  = hz.wb_ctrl_dec;
              end
            end
          end
          LU_STALL: begin
            if (r_cnt <= CW'(1)) w_next_state = RUN;
            else                 w_next_cnt   = r_cnt - CW'(1);
          end
          FLUSH: begin
            hz.pc_we       = 1'b1;
            hz.if_id_flush = 1'b1;
            if (r_cnt <= CW'(1)) w_next_state = RUN;
            else                 w_next_cnt   = r_cnt - CW'(1);
          end
          default: w_next_state = RUN;
        endcase
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic             w_stall_inc, w_flush_inc;
  logic [CNT_W-1:0] r_stall_count, r_flush_count;

  // Every branch-taken cycle is a flush bubble regardless of state, so it masks stall counting.
  assign w_stall_inc = !hz.branch_taken &&
                       ((r_state == RUN && w_lu) || r_state == LU_STALL);
  assign w_flush_inc = hz.branch_taken || (r_state == FLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall_inc && r_stall_count != '1) r_stall_count <= r_stall_count + CNT_W'(1);
      if (w_flush_inc && r_flush_count != '1) r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign hz.stall_count = r_stall_count;
  assign hz.flush_count = r_flush_count;
`else
  assign hz.stall_count = '0;
  assign hz.flush_count = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl (LU_BUBBLES=1, FLUSH_CYCLES=2).
module tb_id_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_fail;

  id_hazard_ctrl_if #(.CTRL_W(4), .REG_W(4), .CNT_W(16)) bus ();

  id_hazard_ctrl #(
    .CTRL_W(4), .REG_W(4), .LU_BUBBLES(1), .FLUSH_CYCLES(2), .CNT_W(16)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e, input logic [3:0] m,
                            input logic [3:0] w, input logic pc, input logic ifid,
                            input logic fl);
    check({tag, ".ex"},    32'(bus.ex_ctrl_out),  32'(e));
    check({tag, ".mem"},   32'(bus.mem_ctrl_out), 32'(m));
    check({tag, ".wb"},    32'(bus.wb_ctrl_out),  32'(w));
    check({tag, ".pc_we"}, 32'(bus.pc_we),        32'(pc));
    check({tag, ".ifid"},  32'(bus.if_id_we),     32'(ifid));
    check({tag, ".flush"}, 32'(bus.if_id_flush),  32'(fl));
  endtask

  task automatic check_cnt(input string tag, input int unsigned st, input int unsigned fl);
    check({tag, ".stall_cnt"}, 32'(bus.stall_count), PERF ? st : 32'd0);
    check({tag, ".flush_cnt"}, 32'(bus.flush_count), PERF ? fl : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.id_valid      = 1'b1;
    bus.ex_ctrl_dec   = 4'hA;
    bus.mem_ctrl_dec  = 4'h3;
    bus.wb_ctrl_dec   = 4'h1;
    bus.id_rn         = 4'd1;
    bus.id_rm         = 4'd2;
    bus.id_uses_rn    = 1'b1;
    bus.id_uses_rm    = 1'b1;
    bus.idex_rd       = 4'd7;
    bus.idex_mem_read = 1'b0;
    bus.branch_taken  = 1'b0;

    // reset held 3 cycles with live decoder inputs
    for (int i = 0; i < 3; i++) begin
      #1;
      check_outs("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    reset = 1'b0;
    check_cnt("post_reset", 0, 0);
    #1;
    check_outs("pass", 4'hA, 4'h3, 4'h1, 1'b1, 1'b1, 1'b0);
    tick();

    bus.id_valid = 1'b0;
    #1;
    check_outs("invalid", 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    tick();

    // load-use on rn: one bubble, then the bubble reaches ID/EX and clears mem_read
    bus.id_valid = 1'b1; bus.ex_ctrl_dec = 4'h5; bus.mem_ctrl_dec = 4'h2; bus.wb_ctrl_dec = 4'h1;
    bus.idex_mem_read = 1'b1; bus.idex_rd = 4'd3; bus.id_rn = 4'd3; bus.id_uses_rn = 1'b1;
    bus.id_rm = 4'd9; bus.id_uses_rm = 1'b1;
    #1;
    check_outs("lu_rn", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.idex_mem_read = 1'b0;
    check_cnt("lu_rn", 1, 0);
    #1;
    check_outs("lu_after", 4'h5, 4'h2, 4'h1, 1'b1, 1'b1, 1'b0);
    tick();

    // matching rm but not read -> no stall
    bus.idex_mem_read = 1'b1; bus.idex_rd = 4'd3; bus.id_rm = 4'd3; bus.id_uses_rm = 1'b0;
    bus.id_rn = 4'd4; bus.id_uses_rn = 1'b1;
    #1;
    check_outs("rm_unused", 4'h5, 4'h2, 4'h1, 1'b1, 1'b1, 1'b0);
    tick();

    // matching rm and read -> stall
    bus.id_uses_rm = 1'b1;
    #1;
    check_outs("lu_rm", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.idex_mem_read = 1'b0;
    check_cnt("lu_rm", 2, 0);

    // branch pulse -> two flush bubbles
    bus.branch_taken = 1'b1;
    #1;
    check_outs("br1", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    bus.branch_taken = 1'b0;
    #1;
    check_outs("br2", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    check_cnt("br", 2, 2);
    #1;
    check_outs("br_done", 4'h5, 4'h2, 4'h1, 1'b1, 1'b1, 1'b0);
    tick();

    // branch and load-use together -> flush wins; lu in FLUSH is ignored
    bus.branch_taken = 1'b1; bus.idex_mem_read = 1'b1;
    #1;
    check_outs("br_lu1", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    bus.branch_taken = 1'b0;
    #1;
    check_outs("br_lu2", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    bus.idex_mem_read = 1'b0;
    check_cnt("br_lu", 2, 4);

    // branch again while in FLUSH reloads the count
    bus.branch_taken = 1'b1;
    #1; tick();
    #1;
    check_outs("reload1", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    bus.branch_taken = 1'b0;
    #1;
    check_outs("reload2", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    check_cnt("reload", 2, 7);
    #1;
    check_outs("reload_done", 4'h5, 4'h2, 4'h1, 1'b1, 1'b1, 1'b0);
    tick();

    // reset during FLUSH with cnt=1
    bus.branch_taken = 1'b1;
    #1; tick();
    bus.branch_taken = 1'b0;
    reset = 1'b1;
    #1;
    check_outs("rst_flush", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    check_cnt("rst_flush", 0, 0);
    #1;
    check_outs("rst_run", 4'h5, 4'h2, 4'h1, 1'b1, 1'b1, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
